mem_wb_stage: RTL

- Pipeline stage directly downstream of the EX-stage ALU.
- Holds the EX/MEM and MEM/WB pipeline registers and a word-addressed data memory. Executes LW/SW at the ALU-computed address and resolves the BEQ outcome.
- Drives the MEM- and WB-side forwarding signals that the ALU consumes: alu_result_MEM, reg_write_*_MEM, reg_write_data, reg_write_*_WB.
- Flags a pending load so the upstream hazard unit can insert a load-use stall.

---
 rtl/mem_wb_stage.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: EX/MEM and MEM/WB registers, word-addressed data memory,
// load/store execution, branch resolution and forwarding outputs for the ALU.
module mem_wb_stage #(
    parameter int DMEM_DEPTH = 256,
    parameter int DMEM_AW    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_EX,
    input  logic [3:0]  op_type_EX,
    input  logic [31:0] alu_result_EX,
    input  logic [31:0] store_data_EX,
    input  logic [4:0]  write_address_EX,
    output logic [3:0]  op_type_MEM,
    output logic [31:0] alu_result_MEM,
    output logic [4:0]  reg_write_address_MEM,
    output logic        reg_write_enable_MEM,
    output logic        load_pending_MEM,
    output logic        branch_taken_MEM,
    output logic [31:0] reg_write_data,
    output logic [4:0]  reg_write_address_WB,
    output logic        reg_write_enable_WB,
    output logic        misalign_error
);

    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;
    localparam logic [3:0] OP_LW  = 4'd6;
    localparam logic [3:0] OP_SW  = 4'd7;
    localparam logic [3:0] OP_BEQ = 4'd8;

    // Register-writing instructions; writes to r0 are suppressed.
    function automatic logic op_writes(input logic v, input logic [3:0] op, input logic [4:0] dest);
        logic w;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_LW: w = 1'b1;
            default:                                      w = 1'b0;
        endcase
        return v && w && (dest != 5'd0);
    endfunction

    logic [31:0]        dmem [DMEM_DEPTH];
    logic               valid_mem_r;
    logic [31:0]        store_data_mem_r;
    logic               writes_mem_r;
    logic [DMEM_AW-1:0] word_idx_s;
    logic               misaligned_s;
    logic               is_lw_s;
    logic               is_sw_s;
    logic [31:0]        load_data_s;
    logic [31:0]        wb_data_next_s;
    logic [4:0]         wb_addr_next_s;

    // EX/MEM pipeline register with decoded enables.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_mem_r           <= 1'b0;
            op_type_MEM           <= 4'd0;
            alu_result_MEM        <= 32'd0;
            store_data_mem_r      <= 32'd0;
            reg_write_address_MEM <= 5'd0;
            writes_mem_r          <= 1'b0;
            reg_write_enable_MEM  <= 1'b0;
            load_pending_MEM      <= 1'b0;
            branch_taken_MEM      <= 1'b0;
        end else begin
            valid_mem_r           <= valid_EX;
            op_type_MEM           <= valid_EX ? op_type_EX : 4'd0;
            alu_result_MEM        <= alu_result_EX;
            store_data_mem_r      <= store_data_EX;
            reg_write_address_MEM <= write_address_EX;
            writes_mem_r          <= op_writes(valid_EX, op_type_EX, write_address_EX);
            // A load's address must never be forwarded as data.
            reg_write_enable_MEM  <= op_writes(valid_EX, op_type_EX, write_address_EX)
                                     && (op_type_EX != OP_LW);
            load_pending_MEM      <= valid_EX && (op_type_EX == OP_LW);
            branch_taken_MEM      <= valid_EX && (op_type_EX == OP_BEQ) && alu_result_EX[0];
        end
    end

    // Memory access decode; upper address bits are ignored so addresses wrap.
    always_comb begin
        word_idx_s   = alu_result_MEM[DMEM_AW+1:2];
        misaligned_s = (alu_result_MEM[1:0] != 2'b00);
        is_lw_s      = valid_mem_r && (op_type_MEM == OP_LW);
        is_sw_s      = valid_mem_r && (op_type_MEM == OP_SW);
        if (misaligned_s) begin
            load_data_s = 32'd0;
        end else begin
            load_data_s = dmem[word_idx_s];
        end
        if (!valid_mem_r) begin
            wb_data_next_s = 32'd0;
            wb_addr_next_s = 5'd0;
        end else if (is_lw_s) begin
            wb_data_next_s = load_data_s;
            wb_addr_next_s = reg_write_address_MEM;
        end else begin
            wb_data_next_s = alu_result_MEM;
            wb_addr_next_s = reg_write_address_MEM;
        end
    end

    // Data memory write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (rst_n && is_sw_s && !misaligned_s) begin
            dmem[word_idx_s] <= store_data_mem_r;
        end
    end

    // MEM/WB pipeline register and sticky misalignment flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_write_data       <= 32'd0;
            reg_write_address_WB <= 5'd0;
            reg_write_enable_WB  <= 1'b0;
            misalign_error       <= 1'b0;
        end else begin
            reg_write_data       <= wb_data_next_s;
            reg_write_address_WB <= wb_addr_next_s;
            reg_write_enable_WB  <= writes_mem_r;
            misalign_error       <= misalign_error || ((is_lw_s || is_sw_s) && misaligned_s);
        end
    end

endmodule
